sram_access_ctrl: RTL and testbench

Sequencer for one SRAM macro's access cycle. It accepts read and write requests over a valid/ready handshake. For each request it drives bitline precharge, then a one-hot wordline, then either the column write drivers or the sense-amp enable, and returns one response per request. It sits between the system-side request port and the array periphery: the bitline write drivers, the sense amps and the row wordline drivers.

---
 rtl/sram_access_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// Access sequencer for one SRAM macro: bitline precharge, wordline + write drive, sense, respond.
// Optional write read-back verification is built in when SRAM_CTRL_WR_VERIFY_EN is defined.
module sram_access_ctrl #(
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 2,
    parameter int SAE_CYC = 1,
    localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    // A request transfers on a rising edge where req_valid and req_ready are both 1;
    // the requester holds req_* stable until then. rsp_valid is a one-cycle strobe, never stalled.
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [COLS-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            pre_en,
    output logic [ROWS-1:0] wl,
    output logic            wr_en,
    output logic [COLS-1:0] wr_data,
    output logic            sae,
    input  logic [COLS-1:0] sa_out,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ACC   = 3'd2,
        S_SENSE = 3'd3,
        S_DONE  = 3'd4
`ifdef SRAM_CTRL_WR_VERIFY_EN
        ,
        S_VPRE  = 3'd5,
        S_VACC  = 3'd6
`endif
    } state_t;

    localparam int MAXC_A = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int MAXC   = (MAXC_A > SAE_CYC) ? MAXC_A : SAE_CYC;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] WL_LD  = CW'(WL_CYC - 1);
    localparam logic [CW-1:0] SAE_LD = CW'(SAE_CYC - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_load;
    logic            w_cnt_zero;

    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic            w_addr_ok;
    logic [ROWS-1:0] w_dec;

    logic            w_req_ready;
    logic            w_pre_en;
    logic            w_wl_act;
    logic            w_wr_en;
    logic            w_sae;
    logic            w_rsp_valid;

    logic            r_req_ready;
    logic            r_pre_en;
    logic [ROWS-1:0] r_wl;
    logic            r_wr_en;
    logic            r_sae;
    logic            r_rsp_valid;
    logic [COLS-1:0] r_rsp_rdata;
    logic            r_rsp_err;
    logic [COLS-1:0] r_wr_data;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_addr_ok  = (int'(r_addr) < ROWS);

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_dec[i] = (r_addr == AW'(i));
        end
    end

    // State register with the dwell counter; the counter reloads whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_PRE;
            S_PRE:   if (w_cnt_zero) w_state_nxt = S_ACC;
            S_ACC: begin
                if (w_cnt_zero) begin
                    if (!r_we) begin
                        w_state_nxt = S_SENSE;
                    end else begin
`ifdef SRAM_CTRL_WR_VERIFY_EN
                        w_state_nxt = S_VPRE;
`else
                        w_state_nxt = S_DONE;
`endif
                    end
                end
            end
`ifdef SRAM_CTRL_WR_VERIFY_EN
            S_VPRE:  if (w_cnt_zero) w_state_nxt = S_VACC;
            S_VACC:  if (w_cnt_zero) w_state_nxt = S_SENSE;
`endif
            S_SENSE: if (w_cnt_zero) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst) w_state_nxt = S_IDLE;
    end

    // Outputs decode the upcoming state so every periphery control leaves a flop.
    always_comb begin
        w_req_ready = 1'b0;
        w_pre_en    = 1'b0;
        w_wl_act    = 1'b0;
        w_wr_en     = 1'b0;
        w_sae       = 1'b0;
        w_rsp_valid = 1'b0;
        w_cnt_load  = '0;
        case (w_state_nxt)
            S_IDLE:  w_req_ready = 1'b1;
            S_PRE: begin
                w_pre_en   = 1'b1;
                w_cnt_load = PRE_LD;
            end
            S_ACC: begin
                w_wl_act   = 1'b1;
                w_wr_en    = r_we && w_addr_ok;
                w_cnt_load = WL_LD;
            end
`ifdef SRAM_CTRL_WR_VERIFY_EN
            S_VPRE: begin
                w_pre_en   = 1'b1;
                w_cnt_load = PRE_LD;
            end
            S_VACC: begin
                w_wl_act   = 1'b1;
                w_cnt_load = WL_LD;
            end
`endif
            S_SENSE: begin
                w_wl_act   = 1'b1;
                w_sae      = 1'b1;
                w_cnt_load = SAE_LD;
            end
            S_DONE:  w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready <= 1'b1;
            r_pre_en    <= 1'b0;
            r_wl        <= '0;
            r_wr_en     <= 1'b0;
            r_sae       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wr_data   <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
        end else begin
            r_req_ready <= w_req_ready;
            r_pre_en    <= w_pre_en;
            r_wl        <= w_wl_act ? w_dec : '0;
            r_wr_en     <= w_wr_en;
            r_sae       <= w_sae;
            r_rsp_valid <= w_rsp_valid;
            if (r_state == S_IDLE && req_valid) begin
                r_we      <= req_we;
                r_addr    <= req_addr;
                r_wr_data <= req_wdata;
            end
            // Sense data lands on the final SENSE edge; a write reaching SENSE is a read-back verify.
            if (r_state == S_SENSE && w_state_nxt == S_DONE) begin
                r_rsp_rdata <= w_addr_ok ? sa_out : '0;
                r_rsp_err   <= !w_addr_ok || (r_we && (sa_out != r_wr_data));
            end else if (r_state == S_ACC && w_state_nxt == S_DONE) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= !w_addr_ok;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign pre_en    = r_pre_en;
    assign wl        = r_wl;
    assign wr_en     = r_wr_en;
    assign sae       = r_sae;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign wr_data   = r_wr_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl (ROWS=6 so out-of-range rows are reachable).
// Timing/response model is a cycle-offset schedule per accepted request.
module tb_sram_access_ctrl;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int P    = 2;
  localparam int W    = 2;
  localparam int S    = 1;
  localparam int AW   = $clog2(ROWS);
`ifdef SRAM_CTRL_WR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [COLS-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_err;
  logic            pre_en;
  logic [ROWS-1:0] wl;
  logic            wr_en;
  logic [COLS-1:0] wr_data;
  logic            sae;
  logic [COLS-1:0] sa_out = '0;
  logic [2:0]      dbg_state;

  sram_access_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .PRE_CYC(P), .WL_CYC(W), .SAE_CYC(S)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pre_en(pre_en), .wl(wl), .wr_en(wr_en), .wr_data(wr_data),
    .sae(sae), .sa_out(sa_out), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [COLS:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit inr(input int x, input int lo, input int hi);
    return (x >= lo) && (x <= hi);
  endfunction

  // sense-amp stimulus: random every cycle unless a directed value is forced
  bit              sa_force = 1'b0;
  logic [COLS-1:0] sa_force_val = '0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      sa_out = sa_force ? sa_force_val : COLS'($urandom);
    end
  end

  // reference model: per-cycle expectations from the offset since acceptance
  bit              rst_prev = 1'b1;
  bit              m_busy = 1'b0;
  int              m_t0 = 0;
  bit              m_we = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [COLS-1:0] m_wdata = '0;
  logic [COLS-1:0] m_wr_data = '0;
  int              off, done_off;
  bit              vw, oor;
  logic            e_ready, e_pre, e_wlact, e_wren, e_sae, e_rspv;
  logic [ROWS-1:0] e_wl;
  logic            r_err;
  logic [COLS-1:0] r_data;

  always @(negedge clk) begin
    cyc++;
    e_pre = 0; e_wlact = 0; e_wren = 0; e_sae = 0; e_rspv = 0; e_wl = '0;
    if (rst_prev) begin
      m_busy = 0;
      m_wr_data = '0;
      exp_q.delete();
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_err", rsp_err, 0);
    end
    e_ready = !m_busy;
    if (m_busy) begin
      off = cyc - m_t0;
      vw  = VERIFY && m_we;
      oor = int'(m_addr) >= ROWS;
      done_off = m_we ? (vw ? 2*P + 2*W + S + 1 : P + W + 1) : P + W + S + 1;
      e_pre   = inr(off, 1, P) || (vw && inr(off, P+W+1, 2*P+W));
      e_wlact = inr(off, P+1, P+W) || (!m_we && inr(off, P+W+1, P+W+S))
                || (vw && inr(off, 2*P+W+1, 2*P+2*W+S));
      e_wren  = m_we && !oor && inr(off, P+1, P+W);
      e_sae   = (!m_we && inr(off, P+W+1, P+W+S)) || (vw && inr(off, 2*P+2*W+1, 2*P+2*W+S));
      e_rspv  = (off == done_off);
      e_wl    = (e_wlact && !oor) ? ROWS'(1) << m_addr : '0;
      if (off == done_off - 1) begin
        r_err  = oor || (vw && (sa_out != m_wdata));
        r_data = oor ? '0 : ((m_we && !VERIFY) ? '0 : sa_out);
        exp_q.push_back({r_err, r_data});
      end
      if (off >= done_off) m_busy = 0;
    end
    chk("req_ready", req_ready, e_ready);
    chk("pre_en", pre_en, e_pre);
    chk("wl", wl, e_wl);
    chk("wr_en", wr_en, e_wren);
    chk("sae", sae, e_sae);
    chk("rsp_valid", rsp_valid, e_rspv);
    chk("wr_data", wr_data, m_wr_data);
    chk("inv_pre_wl", pre_en && (wl != '0), 0);
    chk("inv_wr_sae", wr_en && sae, 0);
    chk("inv_wr_onehot", wr_en && !$onehot(wl), 0);
    if (!rst && req_valid && e_ready) begin
      m_busy = 1;
      m_t0 = cyc;
      m_we = req_we;
      m_addr = req_addr;
      m_wdata = req_wdata;
      m_wr_data = req_wdata;
    end
    rst_prev = rst;
  end

  // response monitor
  logic [COLS:0] mon_e;
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_err", rsp_err, mon_e[COLS]);
        chk("rsp_rdata", rsp_rdata, mon_e[COLS-1:0]);
      end
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [COLS-1:0] d,
                        input bit hold);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    forever begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      n++;
      if (n > 60) begin
        chk("req_accept_timeout", req_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    bit h;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    do_req(1'b1, 3, 8'hA5, 0);
    idle(8);

    sa_force = 1'b1;
    sa_force_val = 8'h3C;
    do_req(1'b0, 5, 8'h00, 0);
    idle(8);
    sa_force = 1'b0;

    do_req(1'b1, 2, 8'h96, 1);
    do_req(1'b0, 1, 8'h00, 0);
    idle(10);

    // reset lands in cycle 3 of a write
    do_req(1'b1, 4, 8'h5A, 0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(8);

    do_req(1'b0, 7, 8'h00, 0);
    idle(8);
    do_req(1'b1, 6, 8'h11, 0);
    idle(8);

    sa_force = 1'b1;
    sa_force_val = 8'hFE;
    do_req(1'b1, 0, 8'hFF, 0);
    idle(14);
    sa_force = 1'b0;

    repeat (150) begin
      h = 1'($urandom_range(0, 1));
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, (1 << AW) - 1)),
             COLS'($urandom), h);
      if (!h) idle($urandom_range(0, 3));
    end
    req_valid = 1'b0;
    idle(20);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
